sdram_cmd_sequencer: RTL

// - Responder side of the SDRAM host command decoder. Takes the decoded strobes
//   (NOP/READA/WRITEA/REFRESH/PRECHARGE/LOAD_MODE), the registered address SADDR and
//   the hidden REF_REQ/INIT_REQ.
// - Issues timed SDRAM pin commands (ACT, RD/WR with auto-precharge, PRE-all, AREF, MRS).
// - Returns CM_ACK and REF_ACK to the decoder. Sits between the decoder and the SDRAM pads.

---
 rtl/sdram_cmd_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer
//   Responder side of the SDRAM host command decoder. Arbitrates decoded host
//   strobes, init-sequence strobes and periodic refresh requests. Issues timed
//   SDRAM pin commands (ACT, RD/WR with auto-precharge, PRE-all, AREF, MRS) and
//   acknowledges accesses and refreshes back to the decoder.
//
// Ports
//   CLK, RESET_N                     clock, async active-low reset
//   NOP, READA, WRITEA               decoded host commands (levels)
//   REFRESH, PRECHARGE, LOAD_MODE    init-sequence strobes (1-cycle pulses)
//   SADDR[ASIZE-1:0]                 {BA, ROW, COL}
//   REF_REQ, INIT_REQ                refresh request, power-up wait in progress
//   CM_ACK, REF_ACK                  1-cycle acknowledges
//   OE                               DQ output enable for write data
//   SA, BA, CS_N/RAS_N/CAS_N/WE_N    SDRAM address, bank and command pins
//   CKE                              clock enable
//
// Build option
//   SDRAM_PWRDN_EN : enter power-down (CKE=0) after 64 idle cycles.
//
// Timing note: every wait state exits so that the next command lands exactly
// N cycles after the previous one, where N is the spacing for that command.
// The counter is therefore loaded with N-2 at issue.

module sdram_cmd_sequencer #(
    parameter int          ROWSIZE  = 12,
    parameter int          COLSIZE  = 9,
    parameter int          ASIZE    = 2 + ROWSIZE + COLSIZE,
    parameter int          TRCD     = 3,
    parameter int          TCL      = 3,
    parameter int          TRP      = 3,
    parameter int          TWR      = 2,
    parameter int          TRFC     = 7,
    parameter int          TMRD     = 2,
    parameter int          BL       = 8,
    parameter logic [11:0] MODE_REG = 12'h033
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               NOP,
    input  logic               READA,
    input  logic               WRITEA,
    input  logic               REFRESH,
    input  logic               PRECHARGE,
    input  logic               LOAD_MODE,
    input  logic [ASIZE-1:0]   SADDR,
    input  logic               REF_REQ,
    input  logic               INIT_REQ,
    output logic               CM_ACK,
    output logic               REF_ACK,
    output logic               OE,
    output logic [ROWSIZE-1:0] SA,
    output logic [1:0]         BA,
    output logic               CS_N,
    output logic               RAS_N,
    output logic               CAS_N,
    output logic               WE_N,
    output logic               CKE
);

    localparam int RD_WAIT = TCL + BL + TRP - 1;
    localparam int WR_WAIT = BL + TWR + TRP - 1;
    localparam int CNT_MAX = (TRFC > TCL + BL + TWR + TRP) ? TRFC : TCL + BL + TWR + TRP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] L_TRCD   = CW'(TRCD - 2);
    localparam logic [CW-1:0] L_TRP    = CW'(TRP - 2);
    localparam logic [CW-1:0] L_TRFC   = CW'(TRFC - 2);
    localparam logic [CW-1:0] L_TMRD   = CW'(TMRD - 2);
    localparam logic [CW-1:0] L_RD     = CW'(RD_WAIT - 2);
    localparam logic [CW-1:0] L_WR     = CW'(WR_WAIT - 2);
    // Counter value seen on the edge that ends the BL-cycle OE window.
    localparam logic [CW-1:0] L_OE_END = CW'(WR_WAIT - 2 - (BL - 1));

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        IDLE, ACT_W, RW, BURST, PRE_W, REF_W, MRS_W
`ifdef SDRAM_PWRDN_EN
        , PWRDN
`endif
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [3:0]         cmd;
    logic               is_wr;
    logic [COLSIZE-1:0] col_q;

    assign {CS_N, RAS_N, CAS_N, WE_N} = cmd;

`ifdef SDRAM_PWRDN_EN
    logic       cke_q;
    logic [5:0] idle_cnt;
    logic       any_req;
    assign any_req = INIT_REQ | PRECHARGE | REFRESH | LOAD_MODE | REF_REQ | READA | WRITEA;
    assign CKE     = cke_q;
`else
    assign CKE = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd     <= C_NOP;
            is_wr   <= 1'b0;
            col_q   <= '0;
            SA      <= '0;
            BA      <= '0;
            OE      <= 1'b0;
            CM_ACK  <= 1'b0;
            REF_ACK <= 1'b0;
`ifdef SDRAM_PWRDN_EN
            cke_q    <= 1'b1;
            idle_cnt <= '0;
`endif
        end else begin
            cmd     <= C_NOP;
            CM_ACK  <= 1'b0;
            REF_ACK <= 1'b0;
`ifdef SDRAM_PWRDN_EN
            idle_cnt <= '0;
`endif
            case (state)
                IDLE: begin
                    if (INIT_REQ) begin
                        // power-up wait: hold NOP, ignore everything else
                    end else if (PRECHARGE) begin
                        cmd    <= C_PRE;
                        SA     <= '0;
                        SA[10] <= 1'b1;
                        state  <= PRE_W;
                        cnt    <= L_TRP;
                    end else if (REFRESH) begin
                        cmd   <= C_AREF;
                        state <= REF_W;
                        cnt   <= L_TRFC;
                    end else if (LOAD_MODE) begin
                        cmd   <= C_MRS;
                        SA    <= ROWSIZE'(MODE_REG);
                        BA    <= 2'b00;
                        state <= MRS_W;
                        cnt   <= L_TMRD;
                    end else if (REF_REQ) begin
                        cmd     <= C_AREF;
                        REF_ACK <= 1'b1;
                        state   <= REF_W;
                        cnt     <= L_TRFC;
                    end else if ((READA || WRITEA) && !NOP) begin
                        // NOP from the decoder vetoes an access in the same cycle
                        cmd   <= C_ACT;
                        BA    <= SADDR[ASIZE-1 -: 2];
                        SA    <= SADDR[COLSIZE +: ROWSIZE];
                        col_q <= SADDR[COLSIZE-1:0];
                        is_wr <= !READA;
                        state <= ACT_W;
                        cnt   <= L_TRCD;
                    end else begin
`ifdef SDRAM_PWRDN_EN
                        idle_cnt <= idle_cnt + 6'd1;
                        if (idle_cnt == 6'd63) begin
                            cke_q <= 1'b0;
                            state <= PWRDN;
                        end
`endif
                    end
                end
                ACT_W: begin
                    if (cnt == '0) state <= RW;
                    else           cnt   <= cnt - 1'b1;
                end
                RW: begin
                    cmd    <= is_wr ? C_WR : C_RD;
                    SA     <= {{(ROWSIZE-COLSIZE){1'b0}}, col_q};
                    SA[10] <= 1'b1;     // auto-precharge
                    CM_ACK <= 1'b1;
                    OE     <= is_wr;
                    cnt    <= is_wr ? L_WR : L_RD;
                    state  <= BURST;
                end
                BURST: begin
                    if (OE && cnt == L_OE_END) OE <= 1'b0;
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                PRE_W, REF_W, MRS_W: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
`ifdef SDRAM_PWRDN_EN
                PWRDN: begin
                    // first edge raises CKE, second returns to IDLE: one NOP (tXP)
                    if (cke_q)        state <= IDLE;
                    else if (any_req) cke_q <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
